// File: rtl/dm_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
// DM_ADDR_W must match the word depth of the dm instance (2^DM_ADDR_W words).
package dm_arbiter_pkg;

    localparam int DM_ADDR_W   = 10;
    localparam int DM_LEN_W    = 4;
    localparam int DM_MAX_WAIT = 4;

    localparam logic [3:0] DM_BE_FULL = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } dm_state_e;

    // Width needed to count 0..max_wait inclusive.
    function automatic int wait_cnt_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dm_burst_ctr.sv
// Holds the latched EXT burst (start address, length, direction) and walks
// the beat counter; produces the wrapped beat address and the last-beat flag.
module dm_burst_ctr
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int LEN_W  = DM_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic              burst_we,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              last_beat
);

    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  beat_cnt;
    logic              we_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg <= '0;
            len_reg  <= '0;
            beat_cnt <= '0;
            we_reg   <= 1'b0;
        end else if (load) begin
            addr_reg <= addr_in;
            len_reg  <= len_in;
            we_reg   <= we_in;
            beat_cnt <= '0;
        end else if (advance) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + LEN_W'(1);
        end
    end

    // Natural-width add wraps the address modulo the dm depth.
    assign beat_addr = addr_reg + ADDR_W'(beat_cnt);
    assign last_beat = (beat_cnt == len_reg);
    assign burst_we  = we_reg;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port dm between the MEM stage and an EXT burst requester.
// CPU wins each cycle; EXT is forced a grant after MAX_WAIT contended cycles.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int LEN_W    = DM_LEN_W,
    parameter int MAX_WAIT = DM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wd,
    output logic [31:0]       cpu_rd,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [LEN_W-1:0]  ext_len,
    input  logic [31:0]       ext_wd,
    output logic              ext_gnt,
    output logic              ext_beat,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rd,
    output logic              ext_done,
    output logic [ADDR_W-1:0] dm_a,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wd,
    output logic              dm_we,
    input  logic [31:0]       dm_rd
);

    localparam int                WAIT_W   = wait_cnt_w(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    dm_state_e         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_idle;
    logic              in_burst;
    logic              grant;
    logic              burst_we;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;
    logic              unused_addr_bits;

    // Qualified with reset_n so nothing reaches dm or EXT while reset is held.
    assign in_idle  = reset_n && (state == ST_IDLE);
    assign in_burst = reset_n && (state == ST_BURST);
    assign grant    = in_idle && ext_req && (!cpu_req || wait_cnt == WAIT_MAX);

    dm_burst_ctr #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_burst_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (grant),
        .advance  (in_burst),
        .we_in    (ext_we),
        .addr_in  (ext_addr),
        .len_in   (ext_len),
        .burst_we (burst_we),
        .beat_addr(beat_addr),
        .last_beat(last_beat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            ext_rvalid <= 1'b0;
            ext_rd     <= '0;
        end else begin
            ext_rvalid <= in_burst && !burst_we;
            if (in_burst && !burst_we)
                ext_rd <= dm_rd;

            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state    <= ST_BURST;
                        wait_cnt <= '0;
                    end else if (ext_req && cpu_req) begin
                        if (wait_cnt != WAIT_MAX)
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (last_beat)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The CPU owns dm in IDLE (including the grant cycle); EXT owns it in BURST.
    always_comb begin
        dm_a  = cpu_addr[ADDR_W+1:2];
        dm_be = cpu_be;
        dm_wd = cpu_wd;
        dm_we = in_idle && cpu_req && cpu_we;
        if (in_burst) begin
            dm_a  = beat_addr;
            dm_be = DM_BE_FULL;
            dm_wd = ext_wd;
            dm_we = burst_we;
        end
    end

    assign cpu_rd    = dm_rd;
    assign cpu_stall = in_burst && cpu_req;
    assign ext_gnt   = grant;
    assign ext_beat  = in_burst;
    assign ext_done  = in_burst && last_beat;

    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized scoreboard bench for dm_arbiter: a transaction-level model queues
// expected grants, beats, read data and CPU accesses; a monitor checks them.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int AW    = 10;
    localparam int LW    = 4;
    localparam int MW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset_n;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wd, cpu_rd;
    logic [3:0]    cpu_be;
    logic          cpu_stall;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [LW-1:0] ext_len;
    logic [31:0]   ext_wd, ext_rd;
    logic          ext_gnt, ext_beat, ext_rvalid, ext_done;
    logic [AW-1:0] dm_a;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wd, dm_rd;
    logic          dm_we;

    dm_arbiter #(.ADDR_W(AW), .LEN_W(LW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
        .ext_wd(ext_wd), .ext_gnt(ext_gnt), .ext_beat(ext_beat), .ext_rvalid(ext_rvalid),
        .ext_rd(ext_rd), .ext_done(ext_done),
        .dm_a(dm_a), .dm_be(dm_be), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // dm behavioural memory driven by the DUT
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    assign dm_rd = mem[dm_a];
    always @(posedge clk)
        if (dm_we) mem[dm_a] <= merge(mem[dm_a], dm_wd, dm_be);

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        stall;
    } cpu_rec_t;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic        done;
    } beat_rec_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } rd_rec_t;

    int        gq[$];
    beat_rec_t bq[$];
    rd_rec_t   rq[$];
    cpu_rec_t  cq[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;

    // model state: beats left in the current burst, and contended-cycle count
    int   m_left = 0, m_base = 0, m_idx = 0, m_wait = 0;
    logic m_we   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr,
                        input logic [3:0] cbe, input logic [31:0] cwd,
                        input logic ereq, input logic ewe, input logic [AW-1:0] eaddr,
                        input logic [LW-1:0] elen, input logic [31:0] ewd);
        cpu_rec_t  cr;
        beat_rec_t br;
        rd_rec_t   rr;
        int        a;
        @(posedge clk);
        #1;
        cyc++;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_be = cbe; cpu_wd = cwd;
        ext_req = ereq; ext_we = ewe; ext_addr = eaddr; ext_len = elen; ext_wd = ewd;
        cr = '{cyc: cyc, a: 0, we: cwe, be: cbe, wd: cwd, rd: 0, stall: 1'b0};
        if (m_left == 0) begin
            if (creq) begin
                a     = int'(caddr[AW+1:2]);
                cr.a  = 32'(a);
                cr.rd = ref_mem[a];
                cq.push_back(cr);
                if (cwe) ref_mem[a] = merge(ref_mem[a], cwd, cbe);
            end
            if (ereq && (!creq || m_wait == MW)) begin
                gq.push_back(cyc);
                m_left = int'(elen) + 1;
                m_base = int'(eaddr);
                m_idx  = 0;
                m_we   = ewe;
                m_wait = 0;
            end else if (ereq && creq) begin
                m_wait = (m_wait < MW) ? m_wait + 1 : MW;
            end else begin
                m_wait = 0;
            end
        end else begin
            if (creq) begin
                cr.stall = 1'b1;
                cq.push_back(cr);
            end
            a  = (m_base + m_idx) % DEPTH;
            br = '{cyc: cyc, a: 32'(a), we: m_we, wd: ewd, done: (m_left == 1)};
            bq.push_back(br);
            if (m_we) begin
                ref_mem[a] = ewd;
            end else begin
                rr = '{cyc: cyc + 1, d: ref_mem[a]};
                rq.push_back(rr);
            end
            m_idx++;
            m_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, '0, '0, $urandom);
    endtask

    // monitor: pops an expectation whenever the DUT presents the matching event
    always @(negedge clk) begin
        if (mon_en) begin
            if (ext_gnt) begin
                if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
                else chk("gnt_cycle", cyc, gq.pop_front());
            end else if (gq.size() > 0 && gq[0] <= cyc) begin
                chk("gnt_missing", 0, 1);
                void'(gq.pop_front());
            end

            if (ext_beat) begin
                if (bq.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    beat_rec_t e;
                    e = bq.pop_front();
                    chk("beat_cycle", cyc, e.cyc);
                    chk("beat_dm_a", dm_a, e.a);
                    chk("beat_dm_we", dm_we, e.we);
                    chk("beat_done", ext_done, e.done);
                    if (e.we) begin
                        chk("beat_dm_wd", dm_wd, e.wd);
                        chk("beat_dm_be", dm_be, 4'hF);
                    end
                end
            end else if (bq.size() > 0 && bq[0].cyc <= cyc) begin
                chk("beat_missing", 0, 1);
                void'(bq.pop_front());
            end
            if (ext_done && !ext_beat) chk("done_without_beat", 1, 0);

            if (ext_rvalid) begin
                if (rq.size() == 0) chk("rvalid_unexpected", 1, 0);
                else begin
                    rd_rec_t e;
                    e = rq.pop_front();
                    chk("rvalid_cycle", cyc, e.cyc);
                    chk("ext_rd", ext_rd, e.d);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                chk("rvalid_missing", 0, 1);
                void'(rq.pop_front());
            end

            if (cpu_req) begin
                if (cq.size() == 0) chk("cpu_rec_missing", 1, 0);
                else begin
                    cpu_rec_t e;
                    e = cq.pop_front();
                    chk("cpu_cycle", cyc, e.cyc);
                    chk("cpu_stall", cpu_stall, e.stall);
                    if (!e.stall) begin
                        chk("cpu_dm_a", dm_a, e.a);
                        chk("cpu_dm_we", dm_we, e.we);
                        chk("cpu_dm_be", dm_be, e.be);
                        if (e.we) chk("cpu_dm_wd", dm_wd, e.wd);
                        else      chk("cpu_rd", cpu_rd, e.rd);
                    end
                end
            end else if (!ext_beat) begin
                chk("dm_we_idle", dm_we, 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h5A00_0000 ^ (32'(i) * 32'h0001_9E37);
            ref_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_9E37);
        end
        reset_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_be = 4'hF; cpu_wd = 32'h1;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = '0; ext_len = '0; ext_wd = 32'h2;

        // reset state, with every request asserted
        #2;
        chk("rst_dm_we", dm_we, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        chk("rst_ext_beat", ext_beat, 0);
        chk("rst_ext_done", ext_done, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_ext_rvalid", ext_rvalid, 0);
        chk("rst_ext_rd", ext_rd, 0);
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // CPU store then load of the same word
        step(1'b1, 1'b1, 32'h10, 4'b0011, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, 0);
        step(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, 0);
        idle(1);

        // EXT-only read burst at 8, four beats
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 10'd8, 4'd3, 0);
        idle(6);

        // contention: both held, EXT forced in after MAX_WAIT
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 32'($urandom), 4'hF, 32'h0, 1'b1, 1'b0, 10'($urandom), 4'd1, 0);
        idle(3);

        // write burst wrapping past the top of dm
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 10'd1023, 4'd1, 0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, '0, '0, 32'hA5A5_0001);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, '0, '0, 32'hA5A5_0002);
        step(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, 0);
        step(1'b1, 1'b0, 32'hFFC, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, 0);

        // CPU store arriving mid write burst is held until after ext_done
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 10'd100, 4'd3, 0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, '0, '0, 32'h1111_0000);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 32'd404, 4'hF, 32'hC0DE_0000, 1'b0, 1'b0, '0, '0, 32'h2222_0000 + 32'(i));
        step(1'b1, 1'b0, 32'd404, 4'hF, 32'h0, 1'b0, 1'b0, '0, '0, 0);
        idle(1);

        // reset in beat 2 of an 8-beat write
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 10'd200, 4'd7, 0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, '0, '0, 32'h3333_0000);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, '0, '0, 32'h3333_0001);
        @(posedge clk);
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; ext_req = 1'b1; ext_wd = 32'h3333_0002;
        gq.delete(); bq.delete(); rq.delete(); cq.delete();
        m_left = 0; m_wait = 0;
        @(negedge clk);
        chk("midrst_dm_we", dm_we, 0);
        chk("midrst_ext_beat", ext_beat, 0);
        chk("midrst_ext_done", ext_done, 0);
        chk("midrst_ext_gnt", ext_gnt, 0);
        chk("midrst_cpu_stall", cpu_stall, 0);
        @(posedge clk);
        #1;
        cpu_req = 1'b0; ext_req = 1'b0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 10'd200, 4'd2, 0);
        idle(5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic          creq, ereq;
            logic [AW-1:0] ea;
            creq = ($urandom_range(0, 9) < 6);
            ereq = ($urandom_range(0, 9) < 3);
            ea   = ($urandom_range(0, 3) == 0) ? 10'(1016 + $urandom_range(0, 7)) : 10'($urandom);
            step(creq, 1'($urandom), {20'h0, 10'($urandom), 2'b00}, 4'($urandom), $urandom,
                 ereq, 1'($urandom), ea, 4'($urandom), $urandom);
        end
        idle(40);

        chk("queues_drained", 32'(gq.size() + bq.size() + rq.size() + cq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
